// File: rtl/tile_scan_gen.sv
// Tile-grid scan generator: turns a VGA col/row stream into tile index and in-tile
// offset using incremental counters, delayed by PIPE pixel strobes.
module tile_scan_gen #(
  parameter int TILE   = 48,
  parameter int GRID_W = 10,
  parameter int GRID_H = 10,
  parameter int X0     = 80,
  parameter int Y0     = 0,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 9,
  parameter int PIPE   = 2,
  parameter int SUB_W  = (TILE > 1) ? $clog2(TILE) : 1,
  parameter int TX_W   = (GRID_W > 1) ? $clog2(GRID_W) : 1,
  parameter int TY_W   = (GRID_H > 1) ? $clog2(GRID_H) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pix_en,
  input  logic [COL_W-1:0] col_addr,
  input  logic [ROW_W-1:0] row_addr,
  output logic [TX_W-1:0]  tile_x,
  output logic [TY_W-1:0]  tile_y,
  output logic [SUB_W-1:0] sub_x,
  output logic [SUB_W-1:0] sub_y,
  output logic             in_grid,
  output logic             line_start,
  output logic             frame_start,
  output logic             out_valid
);

  if (X0 + GRID_W * TILE > (1 << COL_W)) begin : g_bad_col
    $error("tile_scan_gen: grid does not fit in col_addr range");
  end
  if (Y0 + GRID_H * TILE > (1 << ROW_W)) begin : g_bad_row
    $error("tile_scan_gen: grid does not fit in row_addr range");
  end
  if (PIPE < 1 || TILE < 2) begin : g_bad_par
    $error("tile_scan_gen: PIPE must be >= 1 and TILE >= 2");
  end

  localparam logic [COL_W-1:0] X0_C    = COL_W'(X0);
  localparam logic [ROW_W-1:0] Y0_C    = ROW_W'(Y0);
  localparam logic [SUB_W-1:0] SUB_TOP = SUB_W'(TILE - 1);
  localparam logic [TX_W-1:0]  TX_TOP  = TX_W'(GRID_W - 1);
  localparam logic [TY_W-1:0]  TY_TOP  = TY_W'(GRID_H - 1);

  typedef struct packed {
    logic             vld;
    logic             in_grid;
    logic             line_start;
    logic             frame_start;
    logic [TX_W-1:0]  tile_x;
    logic [TY_W-1:0]  tile_y;
    logic [SUB_W-1:0] sub_x;
    logic [SUB_W-1:0] sub_y;
  } stage_t;

  logic             h_act, v_act, h_act_n, v_act_n;
  logic [SUB_W-1:0] sub_x_q, sub_y_q, sub_x_n, sub_y_n;
  logic [TX_W-1:0]  tile_x_q, tile_x_n;
  logic [TY_W-1:0]  tile_y_q, tile_y_n;
  logic [COL_W-1:0] prev_col;
  logic [ROW_W-1:0] prev_row;
  logic             row_chg;
  stage_t           samp_p0;
  stage_t           pipe_p [1:PIPE];

  // Horizontal tracking: any non-consecutive column drops sync until the next X0.
  always_comb begin
    h_act_n  = h_act;
    sub_x_n  = sub_x_q;
    tile_x_n = tile_x_q;
    if (col_addr == X0_C) begin
      h_act_n  = 1'b1;
      sub_x_n  = '0;
      tile_x_n = '0;
    end else if (h_act && (col_addr == prev_col + COL_W'(1))) begin
      if (sub_x_q == SUB_TOP) begin
        sub_x_n = '0;
        if (tile_x_q == TX_TOP) begin
          tile_x_n = '0;
          h_act_n  = 1'b0;
        end else begin
          tile_x_n = tile_x_q + TX_W'(1);
        end
      end else begin
        sub_x_n = sub_x_q + SUB_W'(1);
      end
    end else begin
      h_act_n = 1'b0;
    end
  end

  // Vertical tracking only reacts to a change of row, so many strobes per line are harmless.
  assign row_chg = (row_addr != prev_row);

  always_comb begin
    v_act_n  = v_act;
    sub_y_n  = sub_y_q;
    tile_y_n = tile_y_q;
    if (row_chg) begin
      if (row_addr == Y0_C) begin
        v_act_n  = 1'b1;
        sub_y_n  = '0;
        tile_y_n = '0;
      end else if (v_act && (row_addr == prev_row + ROW_W'(1))) begin
        if (sub_y_q == SUB_TOP) begin
          sub_y_n = '0;
          if (tile_y_q == TY_TOP) begin
            tile_y_n = '0;
            v_act_n  = 1'b0;
          end else begin
            tile_y_n = tile_y_q + TY_W'(1);
          end
        end else begin
          sub_y_n = sub_y_q + SUB_W'(1);
        end
      end else begin
        v_act_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_act    <= 1'b0;
      v_act    <= 1'b0;
      sub_x_q  <= '0;
      sub_y_q  <= '0;
      tile_x_q <= '0;
      tile_y_q <= '0;
      prev_col <= '0;
      prev_row <= '1;
    end else if (pix_en) begin
      h_act    <= h_act_n;
      v_act    <= v_act_n;
      sub_x_q  <= sub_x_n;
      sub_y_q  <= sub_y_n;
      tile_x_q <= tile_x_n;
      tile_y_q <= tile_y_n;
      prev_col <= col_addr;
      prev_row <= row_addr;
    end
  end

  // p0: sample for this strobe, coordinates forced to zero outside the grid
  always_comb begin
    samp_p0         = '0;
    samp_p0.vld     = 1'b1;
    samp_p0.in_grid = h_act_n && v_act_n;
    if (samp_p0.in_grid) begin
      samp_p0.tile_x      = tile_x_n;
      samp_p0.tile_y      = tile_y_n;
      samp_p0.sub_x       = sub_x_n;
      samp_p0.sub_y       = sub_y_n;
      samp_p0.line_start  = (sub_x_n == '0) && (tile_x_n == '0);
      samp_p0.frame_start = samp_p0.line_start && (sub_y_n == '0) && (tile_y_n == '0);
    end
  end

  // p1..pPIPE: delay line advancing only on pixel strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i <= PIPE; i++) pipe_p[i] <= '0;
    end else if (pix_en) begin
      pipe_p[1] <= samp_p0;
      for (int i = 2; i <= PIPE; i++) pipe_p[i] <= pipe_p[i-1];
    end
  end

  assign tile_x      = pipe_p[PIPE].tile_x;
  assign tile_y      = pipe_p[PIPE].tile_y;
  assign sub_x       = pipe_p[PIPE].sub_x;
  assign sub_y       = pipe_p[PIPE].sub_y;
  assign in_grid     = pipe_p[PIPE].in_grid;
  assign line_start  = pipe_p[PIPE].line_start;
  assign frame_start = pipe_p[PIPE].frame_start;
  assign out_valid   = pipe_p[PIPE].vld;

endmodule

// File: tb/tb_tile_scan_gen.sv
// Bench for tile_scan_gen: default instance (PIPE=2) and a PIPE=3 instance share stimulus,
// both compared against a positional run-length model of the scan.
module tb_tile_scan_gen;
  localparam int TILE = 48;
  localparam int GRID = 10;
  localparam int X0   = 80;
  localparam int SPAN = TILE * GRID;
  localparam int GAP  = 3;

  typedef struct packed {
    logic       ig;
    logic       ls;
    logic       fs;
    logic [3:0] tx;
    logic [3:0] ty;
    logic [5:0] sx;
    logic [5:0] sy;
  } smp_t;

  logic       clk = 1'b0, rstn = 1'b1, pix_en = 1'b0;
  logic [9:0] col_addr = '0;
  logic [8:0] row_addr = '0;
  logic [3:0] tile_x_a, tile_y_a, tile_x_b, tile_y_b;
  logic [5:0] sub_x_a, sub_y_a, sub_x_b, sub_y_b;
  logic       in_grid_a, line_start_a, frame_start_a, out_valid_a;
  logic       in_grid_b, line_start_b, frame_start_b, out_valid_b;
  smp_t       obs_a, obs_b;

  int errors = 0;
  int checks = 0;

  int   h_run, v_run, m_prev_col, m_prev_row, n_strobes;
  smp_t hist[$];

  always #5 clk = ~clk;

  tile_scan_gen dut_a (
    .clk(clk), .rstn(rstn), .pix_en(pix_en), .col_addr(col_addr), .row_addr(row_addr),
    .tile_x(tile_x_a), .tile_y(tile_y_a), .sub_x(sub_x_a), .sub_y(sub_y_a),
    .in_grid(in_grid_a), .line_start(line_start_a), .frame_start(frame_start_a),
    .out_valid(out_valid_a));

  tile_scan_gen #(.PIPE(3)) dut_b (
    .clk(clk), .rstn(rstn), .pix_en(pix_en), .col_addr(col_addr), .row_addr(row_addr),
    .tile_x(tile_x_b), .tile_y(tile_y_b), .sub_x(sub_x_b), .sub_y(sub_y_b),
    .in_grid(in_grid_b), .line_start(line_start_b), .frame_start(frame_start_b),
    .out_valid(out_valid_b));

  assign obs_a = {in_grid_a, line_start_a, frame_start_a, tile_x_a, tile_y_a, sub_x_a, sub_y_a};
  assign obs_b = {in_grid_b, line_start_b, frame_start_b, tile_x_b, tile_y_b, sub_x_b, sub_y_b};

  // Position along the line/frame since the last X0/Y0; -1 means out of sync.
  function automatic void model_reset();
    h_run = -1; v_run = -1; m_prev_col = 0; m_prev_row = 511; n_strobes = 0;
    hist.delete();
  endfunction

  function automatic void model_step(int c, int r);
    smp_t s = '0;
    if (c == X0) h_run = 0;
    else if (h_run >= 0 && c == (m_prev_col + 1) % 1024) h_run = (h_run < SPAN) ? h_run + 1 : SPAN;
    else h_run = -1;
    if (r != m_prev_row) begin
      if (r == 0) v_run = 0;
      else if (v_run >= 0 && r == m_prev_row + 1) v_run = (v_run < SPAN) ? v_run + 1 : SPAN;
      else v_run = -1;
    end
    m_prev_col = c;
    m_prev_row = r;
    n_strobes++;
    if (h_run >= 0 && h_run < SPAN && v_run >= 0 && v_run < SPAN) begin
      s.ig = 1'b1;
      s.tx = 4'(h_run / TILE);
      s.sx = 6'(h_run % TILE);
      s.ty = 4'(v_run / TILE);
      s.sy = 6'(v_run % TILE);
      s.ls = (h_run == 0);
      s.fs = (h_run == 0) && (v_run == 0);
    end
    hist.push_back(s);
    if (hist.size() > 8) void'(hist.pop_front());
  endfunction

  function automatic smp_t expect_for(int p);
    if (hist.size() >= p) return hist[hist.size() - p];
    return '0;
  endfunction

  task automatic strobe(input int c, input int r, input int gap);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    col_addr = 10'(c);
    row_addr = 9'(r);
    pix_en   = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    model_step(c, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({obs_a, out_valid_a} !== '0) begin
      errors++; $display("FAIL reset_a got %h want 0", {obs_a, out_valid_a});
    end
    checks++;
    if ({obs_b, out_valid_b} !== '0) begin
      errors++; $display("FAIL reset_b got %h want 0", {obs_b, out_valid_b});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_first_line();
    for (int c = 0; c < 640; c++) begin
      strobe(c, 0, GAP);
      checks++;
      if ({out_valid_a, obs_a} !== {n_strobes >= 2, expect_for(2)}) begin
        errors++; $display("FAIL line0_a col=%0d got %h want %h", c, {out_valid_a, obs_a}, {n_strobes >= 2, expect_for(2)});
      end
      checks++;
      if ({out_valid_b, obs_b} !== {n_strobes >= 3, expect_for(3)}) begin
        errors++; $display("FAIL line0_b col=%0d got %h want %h", c, {out_valid_b, obs_b}, {n_strobes >= 3, expect_for(3)});
      end
      if (c < 3) begin
        checks++;
        if (out_valid_b !== (c == 2)) begin
          errors++; $display("FAIL valid_fill_b strobe=%0d got %b want %b", c + 1, out_valid_b, c == 2);
        end
      end
      if (c == 80 || c == 561) begin
        checks++;
        if (in_grid_a !== 1'b0) begin
          errors++; $display("FAIL edge_out col=%0d got %b want 0", c - 1, in_grid_a);
        end
      end
      if (c == 81) begin
        checks++;
        if (obs_a !== smp_t'{1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 6'd0, 6'd0}) begin
          errors++; $display("FAIL origin_a got %h want frame start at tile 0", obs_a);
        end
      end
      if (c == 82) begin
        checks++;
        if (obs_b !== smp_t'{1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 6'd0, 6'd0}) begin
          errors++; $display("FAIL origin_b got %h want frame start at tile 0", obs_b);
        end
      end
      if (c == 128) begin
        checks++;
        if ({tile_x_a, sub_x_a} !== {4'd0, 6'd47}) begin
          errors++; $display("FAIL col127 got tx=%0d sx=%0d want 0/47", tile_x_a, sub_x_a);
        end
      end
      if (c == 129) begin
        checks++;
        if ({tile_x_a, sub_x_a} !== {4'd1, 6'd0}) begin
          errors++; $display("FAIL col128 got tx=%0d sx=%0d want 1/0", tile_x_a, sub_x_a);
        end
      end
      if (c == 560) begin
        checks++;
        if ({in_grid_a, tile_x_a, sub_x_a} !== {1'b1, 4'd9, 6'd47}) begin
          errors++; $display("FAIL col559 got ig=%b tx=%0d sx=%0d want 1/9/47", in_grid_a, tile_x_a, sub_x_a);
        end
      end
    end
  endtask

  task automatic test_rows();
    for (int r = 1; r < 482; r++) begin
      for (int c = (r == 48) ? 80 : 78; c < 85; c++) begin
        strobe(c, r, GAP);
        checks++;
        if (obs_a !== expect_for(2)) begin
          errors++; $display("FAIL rows_a row=%0d col=%0d got %h want %h", r, c, obs_a, expect_for(2));
        end
        checks++;
        if (obs_b !== expect_for(3)) begin
          errors++; $display("FAIL rows_b row=%0d col=%0d got %h want %h", r, c, obs_b, expect_for(3));
        end
        if (c == 81 && r == 48) begin
          checks++;
          if (obs_a !== smp_t'{1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 6'd0, 6'd0}) begin
            errors++; $display("FAIL row48 got %h want tile_y=1 sub_y=0 line_start", obs_a);
          end
        end
        if (c == 81 && r == 479) begin
          checks++;
          if ({in_grid_a, tile_y_a, sub_y_a} !== {1'b1, 4'd9, 6'd47}) begin
            errors++; $display("FAIL row479 got ig=%b ty=%0d sy=%0d want 1/9/47", in_grid_a, tile_y_a, sub_y_a);
          end
        end
        if (c == 81 && r == 480) begin
          checks++;
          if (in_grid_a !== 1'b0) begin
            errors++; $display("FAIL row480 got ig=%b want 0", in_grid_a);
          end
        end
      end
    end
  endtask

  task automatic test_desync();
    int cols[$];
    for (int c = 78; c <= 100; c++) cols.push_back(c);
    for (int c = 300; c <= 310; c++) cols.push_back(c);
    for (int c = 79; c <= 83; c++) cols.push_back(c);
    foreach (cols[i]) begin
      strobe(cols[i], 0, GAP);
      checks++;
      if (obs_a !== expect_for(2)) begin
        errors++; $display("FAIL desync_a col=%0d got %h want %h", cols[i], obs_a, expect_for(2));
      end
      if (i > 0 && cols[i-1] >= 300 || cols[i] == 80) begin
        checks++;
        if (in_grid_a !== 1'b0) begin
          errors++; $display("FAIL desync_gap col=%0d got ig=%b want 0", cols[i], in_grid_a);
        end
      end
      if (cols[i] == 81) begin
        checks++;
        if ({in_grid_a, tile_x_a, sub_x_a} !== {1'b1, 4'd0, 6'd0}) begin
          errors++; $display("FAIL resync got ig=%b tx=%0d sx=%0d want 1/0/0", in_grid_a, tile_x_a, sub_x_a);
        end
      end
    end
  endtask

  task automatic test_gating();
    for (int c = 78; c <= 105; c++) strobe(c, 1, GAP);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      col_addr = 10'($urandom_range(0, 1023));
      row_addr = 9'($urandom_range(0, 511));
      @(posedge clk);
      #1;
      checks++;
      if ({obs_a, obs_b} !== {expect_for(2), expect_for(3)}) begin
        errors++; $display("FAIL frozen k=%0d got %h/%h want %h/%h", k, obs_a, obs_b, expect_for(2), expect_for(3));
      end
    end
    strobe(106, 1, 0);
    strobe(107, 1, GAP);
    checks++;
    if ({in_grid_a, sub_x_a, sub_y_a} !== {1'b1, 6'd26, 6'd1}) begin
      errors++; $display("FAIL resume got ig=%b sx=%0d sy=%0d want 1/26/1", in_grid_a, sub_x_a, sub_y_a);
    end
  endtask

  task automatic test_random();
    int c = 0;
    int r = 0;
    for (int n = 0; n < 2000; n++) begin
      int pick = $urandom_range(0, 99);
      if (pick < 88) begin
        c++;
        if (c >= 640) begin c = 0; r = (r + 1) % 500; end
      end else if (pick < 92) c = X0;
      else if (pick < 96) c = $urandom_range(0, 1023);
      else begin
        r = $urandom_range(0, 511);
        c = (c + 1) % 640;
      end
      strobe(c, r, $urandom_range(0, 4));
      checks++;
      if ({out_valid_a, obs_a, obs_b} !== {1'b1, expect_for(2), expect_for(3)}) begin
        errors++; $display("FAIL random n=%0d col=%0d row=%0d got %h/%h want %h/%h", n, c, r, obs_a, obs_b, expect_for(2), expect_for(3));
      end
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    for (int r = 0; r < 100; r++) begin
      strobe(80, r, GAP);
      strobe(81, r, GAP);
    end
    for (int c = 78; c <= 300; c++) strobe(c, 100, GAP);
    checks++;
    if ({in_grid_a, tile_y_a} !== {1'b1, 4'd2}) begin
      errors++; $display("FAIL pre_reset got ig=%b ty=%0d want 1/2", in_grid_a, tile_y_a);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({obs_a, out_valid_a, obs_b, out_valid_b} !== '0) begin
      errors++; $display("FAIL async_reset got %h/%h want 0", {obs_a, out_valid_a}, {obs_b, out_valid_b});
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int c = 301; c <= 320; c++) strobe(c, 100, GAP);
    for (int r = 101; r <= 103; r++)
      for (int c = 78; c <= 84; c++) begin
        strobe(c, r, GAP);
        checks++;
        if ({in_grid_a, in_grid_b, obs_a} !== {2'b00, expect_for(2)}) begin
          errors++; $display("FAIL post_reset row=%0d col=%0d got %h want out of grid", r, c, {in_grid_a, in_grid_b, obs_a});
        end
      end
    for (int c = 78; c <= 84; c++) begin
      strobe(c, 0, GAP);
      if (c == 81) begin
        checks++;
        if (obs_a !== smp_t'{1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 6'd0, 6'd0}) begin
          errors++; $display("FAIL new_frame got %h want frame start", obs_a);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_line();
    test_rows();
    test_desync();
    test_gating();
    test_random();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
